wb_cache_arbiter: RTL and testbench

//  Two-master -> one-slave Wishbone (pipelined) arbiter sharing the backing memory between the

---
 rtl/wb_cache_arbiter_pkg.sv | 45 ++++
 rtl/wb_cache_arbiter.sv | 156 +++++++++++++++
 tb/tb_wb_cache_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_cache_arbiter_pkg.sv
// wb_arb_pkg: shared types for the icache/dcache Wishbone arbiter.
//   grant_t    - bus owner encoding, doubles as the arbiter state.
//   wb_req_t   - one master's Wishbone request bundle (cyc, stb, we, adr, dat, sel).
//   arb_decide - owner selection when the bus is free or being released.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_I    = 2'b01,
        GNT_D    = 2'b10
    } grant_t;

    // Word-address width shared with the caches; the request bundle is sized by it.
    localparam int unsigned WB_AW = 12;

    typedef struct packed {
        logic             cyc;
        logic             stb;
        logic             we;
        logic [WB_AW-1:0] adr;
        logic [31:0]      dat;
        logic [3:0]       sel;
    } wb_req_t;

    localparam wb_req_t WB_REQ_IDLE = '0;

    // Contention goes to the dcache unless round-robin is on and the dcache
    // held the most recent grant.
    function automatic grant_t arb_decide(input logic i_cyc,
                                          input logic d_cyc,
                                          input logic last_d,
                                          input logic round_robin);
        grant_t g;
        g = GNT_NONE;
        if (i_cyc && d_cyc) begin
            g = (round_robin && last_d) ? GNT_I : GNT_D;
        end else if (i_cyc) begin
            g = GNT_I;
        end else if (d_cyc) begin
            g = GNT_D;
        end
        return g;
    endfunction

endpackage

// File: rtl/wb_cache_arbiter.sv
// wb_cache_arbiter: two-master (icache, dcache) to one-slave pipelined Wishbone arbiter.
// Ownership is granted per Wishbone cycle and held until the owner drops cyc.
// Ports:
//   cpu_clock_i, cpu_reset_i     clock, synchronous active-high reset
//   i_wb_*  / d_wb_*             icache / dcache master request and responses
//   m_wb_dat_o                   slave read data, broadcast to both masters
//   wb_*_o / wb_*_i              slave request and responses
//   grant_o                      registered owner: 00 none, 01 icache, 10 dcache
//   timeout_o                    sticky flag: owner waited TIMEOUT cycles without ack
module wb_cache_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned AW          = WB_AW,
    parameter bit          ROUND_ROBIN = 1'b1,
    parameter int unsigned TIMEOUT     = 1023
) (
    input  logic          cpu_clock_i,
    input  logic          cpu_reset_i,

    input  logic          i_wb_cyc_i,
    input  logic          i_wb_stb_i,
    input  logic          i_wb_we_i,
    input  logic [AW-1:0] i_wb_adr_i,
    input  logic [31:0]   i_wb_dat_i,
    input  logic [3:0]    i_wb_sel_i,
    output logic          i_wb_stall_o,
    output logic          i_wb_ack_o,
    output logic          i_wb_err_o,

    input  logic          d_wb_cyc_i,
    input  logic          d_wb_stb_i,
    input  logic          d_wb_we_i,
    input  logic [AW-1:0] d_wb_adr_i,
    input  logic [31:0]   d_wb_dat_i,
    input  logic [3:0]    d_wb_sel_i,
    output logic          d_wb_stall_o,
    output logic          d_wb_ack_o,
    output logic          d_wb_err_o,

    output logic [31:0]   m_wb_dat_o,

    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic          wb_we_o,
    output logic [AW-1:0] wb_adr_o,
    output logic [31:0]   wb_dat_o,
    output logic [3:0]    wb_sel_o,
    input  logic          wb_stall_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i,
    input  logic [31:0]   wb_dat_i,

    output logic [1:0]    grant_o,
    output logic          timeout_o
);

    // The request bundle is sized by the package address width.
    if (AW != WB_AW) begin : g_aw_check
        $error("wb_cache_arbiter: AW must equal wb_arb_pkg::WB_AW");
    end

    localparam int unsigned     CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]   TO_VAL = CW'(TIMEOUT);

    grant_t        state_q;
    grant_t        state_d;
    logic          last_d_q;
    logic [CW-1:0] wait_cnt_q;
    logic [CW-1:0] wait_inc;
    logic          owner_cyc;
    logic          wait_tick;

    wb_req_t i_req;
    wb_req_t d_req;
    wb_req_t s_req;

    assign i_req = '{i_wb_cyc_i, i_wb_stb_i, i_wb_we_i, i_wb_adr_i, i_wb_dat_i, i_wb_sel_i};
    assign d_req = '{d_wb_cyc_i, d_wb_stb_i, d_wb_we_i, d_wb_adr_i, d_wb_dat_i, d_wb_sel_i};

    // Muxing depends only on the registered owner; the non-owner sees stall
    // so its pending stb is held rather than lost.
    always_comb begin
        s_req        = WB_REQ_IDLE;
        owner_cyc    = 1'b0;
        i_wb_stall_o = 1'b1;
        i_wb_ack_o   = 1'b0;
        i_wb_err_o   = 1'b0;
        d_wb_stall_o = 1'b1;
        d_wb_ack_o   = 1'b0;
        d_wb_err_o   = 1'b0;
        case (state_q)
            GNT_I: begin
                s_req        = i_req;
                owner_cyc    = i_wb_cyc_i;
                i_wb_stall_o = wb_stall_i;
                i_wb_ack_o   = wb_ack_i;
                i_wb_err_o   = wb_err_i;
            end
            GNT_D: begin
                s_req        = d_req;
                owner_cyc    = d_wb_cyc_i;
                d_wb_stall_o = wb_stall_i;
                d_wb_ack_o   = wb_ack_i;
                d_wb_err_o   = wb_err_i;
            end
            default: begin
            end
        endcase
    end

    assign wb_cyc_o   = s_req.cyc;
    assign wb_stb_o   = s_req.stb;
    assign wb_we_o    = s_req.we;
    assign wb_adr_o   = s_req.adr;
    assign wb_dat_o   = s_req.dat;
    assign wb_sel_o   = s_req.sel;
    assign m_wb_dat_o = wb_dat_i;
    assign grant_o    = state_q;

    // An owner holding cyc keeps the bus; otherwise (idle, or the owner just
    // released) re-arbitrate. Releasing owner has cyc low, so the other master
    // wins if it is waiting, which yields exactly one cyc-low cycle per handoff.
    always_comb begin
        state_d = state_q;
        if (!owner_cyc) begin
            state_d = arb_decide(i_wb_cyc_i, d_wb_cyc_i, last_d_q, ROUND_ROBIN);
        end
    end

    assign wait_inc  = wait_cnt_q + CW'(1);
    assign wait_tick = (state_d == state_q) && !wb_ack_i && owner_cyc;

    always_ff @(posedge cpu_clock_i) begin
        if (cpu_reset_i) begin
            state_q    <= GNT_NONE;
            last_d_q   <= 1'b0;
            wait_cnt_q <= '0;
            timeout_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != GNT_NONE) begin
                last_d_q <= (state_d == GNT_D);
            end
            if ((state_d != state_q) || wb_ack_i) begin
                wait_cnt_q <= '0;
            end else if (owner_cyc && (wait_cnt_q != '1)) begin
                wait_cnt_q <= wait_inc;
            end
            // Flag rises at the edge closing the TIMEOUT-th ackless owner cycle.
            if ((TIMEOUT != 0) && wait_tick && (wait_cnt_q != '1) && (wait_inc == TO_VAL)) begin
                timeout_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_cache_arbiter.sv
// Directed bench for wb_cache_arbiter: one round-robin instance and one
// fixed-dcache-priority instance share every input; both use TIMEOUT=8.
module tb_wb_cache_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_cyc = 1'b0, i_stb = 1'b0, i_we = 1'b0;
    logic [11:0] i_adr = '0;
    logic [31:0] i_dat = '0;
    logic [3:0]  i_sel = '0;
    logic        d_cyc = 1'b0, d_stb = 1'b0, d_we = 1'b0;
    logic [11:0] d_adr = '0;
    logic [31:0] d_dat = '0;
    logic [3:0]  d_sel = '0;
    logic        s_stall = 1'b0, s_ack = 1'b0, s_err = 1'b0;
    logic [31:0] s_dat = '0;

    logic        r_i_stall, r_i_ack, r_i_err, r_d_stall, r_d_ack, r_d_err;
    logic [31:0] r_mdat, r_dat;
    logic        r_cyc, r_stb, r_we, r_timeout;
    logic [11:0] r_adr;
    logic [3:0]  r_sel;
    logic [1:0]  r_grant;

    logic        f_i_stall, f_i_ack, f_i_err, f_d_stall, f_d_ack, f_d_err;
    logic [31:0] f_mdat, f_dat;
    logic        f_cyc, f_stb, f_we, f_timeout;
    logic [11:0] f_adr;
    logic [3:0]  f_sel;
    logic [1:0]  f_grant;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_cache_arbiter #(.AW(12), .ROUND_ROBIN(1'b1), .TIMEOUT(8)) u_rr (
        .cpu_clock_i(clk), .cpu_reset_i(rst),
        .i_wb_cyc_i(i_cyc), .i_wb_stb_i(i_stb), .i_wb_we_i(i_we), .i_wb_adr_i(i_adr),
        .i_wb_dat_i(i_dat), .i_wb_sel_i(i_sel),
        .i_wb_stall_o(r_i_stall), .i_wb_ack_o(r_i_ack), .i_wb_err_o(r_i_err),
        .d_wb_cyc_i(d_cyc), .d_wb_stb_i(d_stb), .d_wb_we_i(d_we), .d_wb_adr_i(d_adr),
        .d_wb_dat_i(d_dat), .d_wb_sel_i(d_sel),
        .d_wb_stall_o(r_d_stall), .d_wb_ack_o(r_d_ack), .d_wb_err_o(r_d_err),
        .m_wb_dat_o(r_mdat),
        .wb_cyc_o(r_cyc), .wb_stb_o(r_stb), .wb_we_o(r_we), .wb_adr_o(r_adr),
        .wb_dat_o(r_dat), .wb_sel_o(r_sel),
        .wb_stall_i(s_stall), .wb_ack_i(s_ack), .wb_err_i(s_err), .wb_dat_i(s_dat),
        .grant_o(r_grant), .timeout_o(r_timeout)
    );

    wb_cache_arbiter #(.AW(12), .ROUND_ROBIN(1'b0), .TIMEOUT(8)) u_fx (
        .cpu_clock_i(clk), .cpu_reset_i(rst),
        .i_wb_cyc_i(i_cyc), .i_wb_stb_i(i_stb), .i_wb_we_i(i_we), .i_wb_adr_i(i_adr),
        .i_wb_dat_i(i_dat), .i_wb_sel_i(i_sel),
        .i_wb_stall_o(f_i_stall), .i_wb_ack_o(f_i_ack), .i_wb_err_o(f_i_err),
        .d_wb_cyc_i(d_cyc), .d_wb_stb_i(d_stb), .d_wb_we_i(d_we), .d_wb_adr_i(d_adr),
        .d_wb_dat_i(d_dat), .d_wb_sel_i(d_sel),
        .d_wb_stall_o(f_d_stall), .d_wb_ack_o(f_d_ack), .d_wb_err_o(f_d_err),
        .m_wb_dat_o(f_mdat),
        .wb_cyc_o(f_cyc), .wb_stb_o(f_stb), .wb_we_o(f_we), .wb_adr_o(f_adr),
        .wb_dat_o(f_dat), .wb_sel_o(f_sel),
        .wb_stall_i(s_stall), .wb_ack_i(s_ack), .wb_err_i(s_err), .wb_dat_i(s_dat),
        .grant_o(f_grant), .timeout_o(f_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after each rising edge; checks follow 1 unit later.
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_cyc = 1'b0; i_stb = 1'b0; i_we = 1'b0; i_adr = '0; i_sel = '0;
        d_cyc = 1'b0; d_stb = 1'b0; d_we = 1'b0; d_adr = '0; d_sel = '0; d_dat = '0;
        s_stall = 1'b0; s_ack = 1'b0; s_err = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        adv();
        adv();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        idle_inputs();
        adv();
        adv();
        #1;
        chk("rst_grant", r_grant, 0);
        chk("rst_timeout", r_timeout, 0);
        chk("rst_cyc", r_cyc, 0);
        chk("rst_i_stall", r_i_stall, 1);
        chk("rst_d_stall", r_d_stall, 1);
        chk("rst_f_grant", f_grant, 0);
        rst = 1'b0;

        // dcache-only write, slave acks two cycles after acceptance
        adv();
        d_cyc = 1; d_stb = 1; d_we = 1; d_adr = 12'h010; d_dat = 32'hCAFE0001; d_sel = 4'b0011;
        #1;
        chk("t1_grant_lat", r_grant, 0);
        chk("t1_cyc_lat", r_cyc, 0);
        chk("t1_dstall_lat", r_d_stall, 1);
        adv(); #1;
        chk("t1_grant", r_grant, 2);
        chk("t1_cyc", r_cyc, 1);
        chk("t1_stb", r_stb, 1);
        chk("t1_we", r_we, 1);
        chk("t1_adr", r_adr, 12'h010);
        chk("t1_dat", r_dat, 32'hCAFE0001);
        chk("t1_sel", r_sel, 4'b0011);
        chk("t1_dstall", r_d_stall, 0);
        chk("t1_istall_a", r_i_stall, 1);
        adv(); d_stb = 0; #1;
        chk("t1_dack_0", r_d_ack, 0);
        chk("t1_stb_off", r_stb, 0);
        adv(); s_ack = 1; #1;
        chk("t1_dack_1", r_d_ack, 1);
        chk("t1_iack_none", r_i_ack, 0);
        chk("t1_istall_b", r_i_stall, 1);
        adv(); s_ack = 0; d_cyc = 0; d_we = 0; #1;
        chk("t1_rel_cyc", r_cyc, 0);
        chk("t1_rel_grant", r_grant, 2);
        chk("t1_dack_2", r_d_ack, 0);
        adv(); s_ack = 1; #1;
        chk("t1_idle_grant", r_grant, 0);
        chk("stray_dack", r_d_ack, 0);
        chk("stray_iack", r_i_ack, 0);
        adv(); s_ack = 0;

        // icache 4-beat fill, slave stalls the second beat once
        i_cyc = 1; i_stb = 1; i_we = 0; i_adr = 12'h020; i_sel = 4'hF; #1;
        chk("t2_grant_lat", r_grant, 0);
        chk("t2_istall_lat", r_i_stall, 1);
        adv(); #1;
        chk("t2_grant", r_grant, 1);
        chk("t2_adr0", r_adr, 12'h020);
        chk("t2_istall0", r_i_stall, 0);
        chk("t2_dstall", r_d_stall, 1);
        adv(); i_adr = 12'h021; s_stall = 1; s_ack = 1; s_dat = 32'h10000020; #1;
        chk("t2_istall_hold", r_i_stall, 1);
        chk("t2_ack0", r_i_ack, 1);
        chk("t2_dack0", r_d_ack, 0);
        chk("t2_rdat0", r_mdat, 32'h10000020);
        chk("t2_adr1_held", r_adr, 12'h021);
        adv(); s_stall = 0; s_ack = 0; #1;
        chk("t2_adr1", r_adr, 12'h021);
        chk("t2_istall1", r_i_stall, 0);
        chk("t2_noack", r_i_ack, 0);
        adv(); i_adr = 12'h022; s_ack = 1; s_dat = 32'h10000021; #1;
        chk("t2_adr2", r_adr, 12'h022);
        chk("t2_ack1", r_i_ack, 1);
        chk("t2_rdat1", r_mdat, 32'h10000021);
        adv(); i_adr = 12'h023; s_dat = 32'h10000022; #1;
        chk("t2_adr3", r_adr, 12'h023);
        chk("t2_ack2", r_i_ack, 1);
        adv(); i_stb = 0; s_dat = 32'h10000023; #1;
        chk("t2_ack3", r_i_ack, 1);
        chk("t2_dack3", r_d_ack, 0);
        chk("t2_stb_off", r_stb, 0);
        chk("t2_cyc_on", r_cyc, 1);
        adv(); i_cyc = 0; s_ack = 0; #1;
        chk("t2_rel_cyc", r_cyc, 0);
        chk("t2_rel_grant", r_grant, 1);
        chk("t2_iack_end", r_i_ack, 0);
        adv(); #1;
        chk("t2_idle_grant", r_grant, 0);

        // Round-robin contention from reset
        do_reset();
        adv();
        i_cyc = 1; i_stb = 1; i_adr = 12'h030; i_sel = 4'hF;
        d_cyc = 1; d_stb = 1; d_we = 1; d_adr = 12'h040; d_sel = 4'hF; d_dat = 32'h0000D040;
        #1;
        chk("t3_grant_lat", r_grant, 0);
        adv(); #1;
        chk("t3_d_first", r_grant, 2);
        chk("t3_adr_d", r_adr, 12'h040);
        chk("t3_istall", r_i_stall, 1);
        chk("t3_dstall", r_d_stall, 0);
        adv(); d_stb = 0; s_ack = 1; #1;
        chk("t3_dack", r_d_ack, 1);
        chk("t3_iack_none", r_i_ack, 0);
        adv(); s_ack = 0; d_cyc = 0; d_we = 0; #1;
        chk("t3_gap_cyc", r_cyc, 0);
        chk("t3_gap_grant", r_grant, 2);
        chk("t3_gap_istall", r_i_stall, 1);
        adv(); #1;
        chk("t3_i_second", r_grant, 1);
        chk("t3_i_cyc", r_cyc, 1);
        chk("t3_adr_i", r_adr, 12'h030);
        chk("t3_i_stall_open", r_i_stall, 0);
        adv(); i_stb = 0; s_ack = 1; #1;
        chk("t3_iack", r_i_ack, 1);
        chk("t3_dack_none", r_d_ack, 0);
        adv(); s_ack = 0; i_cyc = 0; #1;
        chk("t3_i_rel_cyc", r_cyc, 0);
        adv(); d_cyc = 1; d_stb = 1; d_adr = 12'h041; #1;
        chk("t3_solo_lat", r_grant, 0);
        adv(); #1;
        chk("t3_solo_d", r_grant, 2);
        adv(); d_stb = 0; s_ack = 1; #1;
        adv(); s_ack = 0; d_cyc = 0; #1;
        adv();
        i_cyc = 1; i_stb = 1; i_adr = 12'h031;
        d_cyc = 1; d_stb = 1; d_adr = 12'h042;
        #1;
        chk("t3_rep_lat", r_grant, 0);
        adv(); #1;
        chk("t3_rep_i_first", r_grant, 1);
        chk("t3_rep_adr_i", r_adr, 12'h031);
        adv(); i_stb = 0; s_ack = 1; #1;
        chk("t3_rep_iack", r_i_ack, 1);
        adv(); s_ack = 0; i_cyc = 0; #1;
        chk("t3_rep_gap", r_cyc, 0);
        adv(); #1;
        chk("t3_rep_d_second", r_grant, 2);
        chk("t3_rep_adr_d", r_adr, 12'h042);
        adv(); d_stb = 0; s_ack = 1; #1;
        chk("t3_rep_dack", r_d_ack, 1);
        adv(); s_ack = 0; d_cyc = 0; #1;
        adv(); #1;
        chk("t3_end_grant", r_grant, 0);

        // Fixed dcache priority
        do_reset();
        adv(); d_cyc = 1; d_stb = 1; d_adr = 12'h050; #1;
        chk("t4_lat", f_grant, 0);
        adv(); #1;
        chk("t4_solo_d", f_grant, 2);
        adv(); d_stb = 0; s_ack = 1; #1;
        chk("t4_solo_dack", f_d_ack, 1);
        adv(); s_ack = 0; d_cyc = 0; #1;
        chk("t4_solo_rel", f_cyc, 0);
        adv();
        i_cyc = 1; i_stb = 1; i_adr = 12'h060; i_sel = 4'hF;
        d_cyc = 1; d_stb = 1; d_adr = 12'h051;
        #1;
        chk("t4_cont_lat", f_grant, 0);
        adv(); #1;
        chk("t4_fx_d_wins", f_grant, 2);
        chk("t4_rr_i_wins", r_grant, 1);
        chk("t4_fx_adr", f_adr, 12'h051);
        chk("t4_fx_istall", f_i_stall, 1);
        adv(); d_stb = 0; s_ack = 1; #1;
        chk("t4_fx_dack", f_d_ack, 1);
        chk("t4_fx_iack_none", f_i_ack, 0);
        adv(); s_ack = 0; d_cyc = 0; #1;
        chk("t4_fx_gap", f_cyc, 0);
        adv(); d_cyc = 1; d_stb = 1; d_adr = 12'h052; #1;
        chk("t4_fx_i_when_idle", f_grant, 1);
        chk("t4_fx_adr_i", f_adr, 12'h060);
        chk("t4_fx_dstall", f_d_stall, 1);
        adv(); i_stb = 0; s_ack = 1; #1;
        chk("t4_fx_iack", f_i_ack, 1);
        chk("t4_fx_dack_none", f_d_ack, 0);
        adv(); s_ack = 0; i_cyc = 0; #1;
        chk("t4_fx_i_rel", f_cyc, 0);
        adv(); #1;
        chk("t4_fx_d_again", f_grant, 2);
        chk("t4_fx_adr_d2", f_adr, 12'h052);
        adv(); d_stb = 0; s_ack = 1; #1;
        adv(); s_ack = 0; d_cyc = 0; #1;

        // Reset in the middle of an icache fill
        do_reset();
        adv(); i_cyc = 1; i_stb = 1; i_adr = 12'h020; i_sel = 4'hF; #1;
        adv(); #1;
        chk("t5_grant", r_grant, 1);
        adv(); i_adr = 12'h021; s_ack = 1; #1;
        adv(); i_adr = 12'h022; rst = 1; #1;
        chk("t5_cyc_before", r_cyc, 1);
        adv(); #1;
        chk("t5_cyc_abort", r_cyc, 0);
        chk("t5_grant_abort", r_grant, 0);
        chk("t5_iack_drop", r_i_ack, 0);
        chk("t5_istall", r_i_stall, 1);
        adv(); rst = 0; i_cyc = 0; i_stb = 0; s_ack = 1; #1;
        chk("t5_late_ack", r_i_ack, 0);
        chk("t5_grant_idle", r_grant, 0);
        adv(); s_ack = 0;

        // Timeout with TIMEOUT=8, slave withholds ack
        do_reset();
        adv(); d_cyc = 1; d_stb = 1; d_adr = 12'h070; d_sel = 4'hF; #1;
        chk("t6_lat_grant", r_grant, 0);
        chk("t6_lat_to", r_timeout, 0);
        adv(); #1;
        chk("t6_grant", r_grant, 2);
        adv(); d_stb = 0;
        repeat (6) adv();
        #1;
        chk("t6_to_8th", r_timeout, 0);
        adv(); #1;
        chk("t6_to_set", r_timeout, 1);
        chk("t6_grant_held", r_grant, 2);
        adv(); s_ack = 1; #1;
        chk("t6_late_dack", r_d_ack, 1);
        chk("t6_to_sticky_ack", r_timeout, 1);
        adv(); s_ack = 0; d_cyc = 0; #1;
        chk("t6_to_sticky_rel", r_timeout, 1);
        adv(); #1;
        chk("t6_grant_idle", r_grant, 0);
        chk("t6_to_sticky_idle", r_timeout, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
